dp_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one five-operand signed arithmetic datapath (a..e in, y out, valid/ready on both sides) among N requesters. Each accepted operand bundle is forwarded unchanged to the datapath. The granted requester's index is pushed into an in-order tag FIFO, and each datapath result is steered back to the requester that issued it. Sits between the requester-side logic and the shared datapath instance; the datapath itself is unchanged.

---
 rtl/dp_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_dp_rr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_rr_arbiter.sv
// dp_rr_arbiter
// Round-robin arbiter that shares one five-operand arithmetic datapath among
// N requesters. The granted requester's operands go to the datapath unchanged,
// its index is queued in an in-order tag FIFO, and each returned result is
// steered back to the requester at the head of that FIFO.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester operand handshake (req_ready one-hot)
//   req_a..req_e          per-requester operands, requester i in [16i+15:16i]
//   in_valid/in_ready     operand handshake towards the datapath
//   a..e                  operands of the granted requester
//   out_valid/out_ready   result handshake from the datapath
//   y                     datapath result
//   rsp_valid/rsp_ready   per-requester result handshake (rsp_valid one-hot)
//   rsp_y                 result broadcast to all requesters
//   inflight              tag FIFO occupancy
//   err                   sticky: a result arrived with no outstanding tag
module dp_rr_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int IDW   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  output logic [N-1:0]             req_ready,
  input  logic [16*N-1:0]          req_a,
  input  logic [16*N-1:0]          req_b,
  input  logic [16*N-1:0]          req_c,
  input  logic [16*N-1:0]          req_d,
  input  logic [16*N-1:0]          req_e,
  output logic                     in_valid,
  input  logic                     in_ready,
  output logic [15:0]              a,
  output logic [15:0]              b,
  output logic [15:0]              c,
  output logic [15:0]              d,
  output logic [15:0]              e,
  input  logic                     out_valid,
  output logic                     out_ready,
  input  logic [31:0]              y,
  output logic [N-1:0]             rsp_valid,
  input  logic [N-1:0]             rsp_ready,
  output logic [31:0]              rsp_y,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  logic           found;
  logic [IDW-1:0] tags [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [IDW-1:0] head;
  logic           nonempty;
  logic           can_issue;
  logic           issue;
  logic           pop;

  // First valid requester after ptr, wrapping modulo N.
  always_comb begin
    gnt   = ptr;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= unsigned'(N); k++) begin
      cand = IDW'((32'(ptr) + k) % unsigned'(N));
      if (!found && req_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    e = '0;
    for (int unsigned i = 0; i < unsigned'(N); i++) begin
      if (gnt == IDW'(i)) begin
        a = req_a[16*i +: 16];
        b = req_b[16*i +: 16];
        c = req_c[16*i +: 16];
        d = req_d[16*i +: 16];
        e = req_e[16*i +: 16];
      end
    end
  end

  // Eligibility uses the registered occupancy only, so in_valid never
  // depends on in_ready or on a same-cycle pop.
  assign can_issue = (inflight < CW'(DEPTH)) && (|req_valid);
  assign in_valid  = can_issue;
  assign issue     = in_valid && in_ready;

  assign head      = tags[rd_ptr];
  assign nonempty  = (inflight != '0);
  assign out_ready = nonempty && rsp_ready[head];
  assign pop       = out_valid && out_ready;
  assign rsp_y     = y;

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (issue) begin
      req_ready[gnt] = 1'b1;
    end
    if (out_valid && nonempty) begin
      rsp_valid[head] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= IDW'(N - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (issue) begin
        ptr    <= gnt;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (issue && !pop) begin
        inflight <= inflight + CW'(1);
      end else if (pop && !issue) begin
        inflight <= inflight - CW'(1);
      end
      if (out_valid && !nonempty) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tags[wr_ptr] <= gnt;
    end
  end

endmodule

// File: tb/tb_dp_rr_arbiter.sv
// Scoreboard bench for dp_rr_arbiter: expected responses are queued when the
// stimulus is issued, and a forked monitor pops and compares them whenever a
// requester-side response handshake occurs.
module tb_dp_rr_arbiter;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_a, req_b, req_c, req_d, req_e;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a, b, c, d, e;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      y;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [31:0]      rsp_y;
  logic [$clog2(DEPTH):0] inflight;
  logic             err;

  always #5 clk = ~clk;

  dp_rr_arbiter #(.N(N), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d), .req_e(req_e),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .inflight(inflight), .err(err)
  );

  // Requester model: requester i keeps req_valid up until it has been
  // accepted want[i] times in total; operand e advances by one per accept.
  logic [15:0] op_a [N];
  logic [15:0] op_b [N];
  logic [15:0] op_c [N];
  logic [15:0] op_d [N];
  logic [15:0] op_e [N];
  int unsigned iss_cnt [N] = '{default: 0};
  int unsigned want    [N] = '{default: 0};
  int unsigned ebase   [N] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) iss_cnt[i] <= iss_cnt[i] + 1;
    end
  end

  always_comb begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    req_e = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = iss_cnt[i] < want[i];
      req_a[16*i +: 16]  = op_a[i];
      req_b[16*i +: 16]  = op_b[i];
      req_c[16*i +: 16]  = op_c[i];
      req_d[16*i +: 16]  = op_d[i];
      req_e[16*i +: 16]  = op_e[i] + 16'(iss_cnt[i] - ebase[i]);
    end
  end

  // Datapath model: y = a*b + c*d + e, one cycle latency, results held in
  // order; dp_en gates out_valid, dp_force presents a spurious result.
  logic        dp_en;
  logic        dp_force;
  logic [31:0] force_y;
  logic [31:0] dp_mem [64];
  int unsigned dp_wr = 0;
  int unsigned dp_rd = 0;

  function automatic logic [31:0] dpf(logic [15:0] fa, logic [15:0] fb,
                                      logic [15:0] fc, logic [15:0] fd,
                                      logic [15:0] fe);
    int sa, sb, sc, sd, se;
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    sc = int'($signed(fc));
    sd = int'($signed(fd));
    se = int'($signed(fe));
    return 32'(sa * sb + sc * sd + se);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      dp_wr <= 0;
      dp_rd <= 0;
    end else begin
      if (in_valid && in_ready) begin
        dp_mem[dp_wr % 64] <= dpf(a, b, c, d, e);
        dp_wr <= dp_wr + 1;
      end
      if (out_valid && out_ready && !dp_force) dp_rd <= dp_rd + 1;
    end
  end

  assign out_valid = dp_force || (dp_en && (dp_wr != dp_rd));
  assign y         = dp_force ? force_y : dp_mem[dp_rd % 64];

  typedef struct {
    int unsigned owner;
    logic [31:0] y;
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(int i, int av, int bv, int cv, int dv, int ev);
    op_a[i]  = 16'(av);
    op_b[i]  = 16'(bv);
    op_c[i]  = 16'(cv);
    op_d[i]  = 16'(dv);
    op_e[i]  = 16'(ev);
    ebase[i] = iss_cnt[i];
  endtask

  task automatic request(int i, int n);
    want[i] = iss_cnt[i] + unsigned'(n);
  endtask

  task automatic expect_rsp(int unsigned owner, logic [31:0] yv);
    exp_t ex;
    ex.owner = owner;
    ex.y     = yv;
    exp_q.push_back(ex);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && ((rsp_valid & rsp_ready) != '0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b expected no response", rsp_valid);
        end else begin
          exp_t ex;
          ex = exp_q.pop_front();
          check("rsp_owner", 32'(rsp_valid), 32'(1) << ex.owner);
          check("rsp_y", rsp_y, ex.y);
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && inflight == '0 && req_valid == '0) break;
      tick();
    end
    check("drain_queue", 32'(exp_q.size()), 0);
    check("drain_inflight", 32'(inflight), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) set_ops(i, 0, 0, 0, 0, 0);
    in_ready  = 1'b1;
    rsp_ready = '1;
    dp_en     = 1'b1;
    dp_force  = 1'b0;
    force_y   = '0;
    rst       = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_valid", 32'(in_valid), 0);
    check("rst_out_ready", 32'(out_ready), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    tick();
    rst = 1'b0;

    // Single request from requester 2: 1*2 + 3*4 + 5 = 19
    set_ops(2, 1, 2, 3, 4, 5);
    expect_rsp(2, 19);
    request(2, 1);
    @(negedge clk);
    check("t1_in_valid", 32'(in_valid), 1);
    check("t1_req_ready", 32'(req_ready), 32'b0100);
    check("t1_a", 32'(a), 1);
    check("t1_e", 32'(e), 5);
    check("t1_inflight0", 32'(inflight), 0);
    tick();
    @(negedge clk);
    check("t1_inflight1", 32'(inflight), 1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("t1_rsp_y", rsp_y, 19);
    tick();
    @(negedge clk);
    check("t1_inflight2", 32'(inflight), 0);

    // Round robin from reset: y = 2*(10+i) - 12 + e, e = i then i+1
    tick();
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 10 + i, 2, -3, 4, i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expect_rsp(unsigned'(i), 32'(3 * i + 8 + r));
    for (int i = 0; i < N; i++) request(i, 2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
      tick();
    end
    drain();

    // Full FIFO with results held back
    tick();
    dp_en = 1'b0;
    set_ops(0, 10, 2, -3, 4, 0);
    set_ops(1, 11, 2, -3, 4, 0);
    expect_rsp(0, 8);
    expect_rsp(1, 10);
    expect_rsp(0, 9);
    expect_rsp(1, 11);
    expect_rsp(0, 10);
    expect_rsp(1, 12);
    request(0, 3);
    request(1, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'b0001 : 32'b0010);
      tick();
    end
    @(negedge clk);
    check("t3_full_inflight", 32'(inflight), 4);
    check("t3_full_in_valid", 32'(in_valid), 0);
    tick();
    dp_en = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_in_valid", 32'(in_valid), 0);
    tick();
    dp_en = 1'b0;
    @(negedge clk);
    check("t3_next_in_valid", 32'(in_valid), 1);
    check("t3_next_grant", 32'(req_ready), 32'b0001);
    check("t3_next_inflight", 32'(inflight), 3);
    tick();
    dp_en = 1'b1;
    drain();

    // Response stall on requester 1: y = 22 - 12 + 0 = 10
    tick();
    set_ops(1, 11, 2, -3, 4, 0);
    rsp_ready = 4'b1101;
    expect_rsp(1, 10);
    request(1, 1);
    @(negedge clk);
    check("t4_grant", 32'(req_ready), 32'b0010);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_out_ready", 32'(out_ready), 0);
      check("t4_rsp_valid", 32'(rsp_valid), 32'b0010);
      check("t4_rsp_y", rsp_y, 10);
      check("t4_inflight", 32'(inflight), 1);
      tick();
    end
    rsp_ready = '1;
    @(negedge clk);
    check("t4_out_ready_up", 32'(out_ready), 1);
    tick();
    @(negedge clk);
    check("t4_inflight_pop", 32'(inflight), 0);

    // Push and pop together at inflight 2, ten ops across pointer wrap
    tick();
    dp_en = 1'b0;
    set_ops(2, 12, 2, -3, 4, 100);
    set_ops(3, 13, 2, -3, 4, 200);
    for (int j = 0; j < 5; j++) begin
      expect_rsp(2, 32'(112 + j));
      expect_rsp(3, 32'(214 + j));
    end
    request(2, 5);
    request(3, 5);
    tick();
    tick();
    dp_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t5_inflight", 32'(inflight), 2);
      check("t5_grant", 32'(req_ready), (k % 2 == 0) ? 32'b0100 : 32'b1000);
      tick();
    end
    drain();

    // Spurious result with empty FIFO
    tick();
    dp_force = 1'b1;
    force_y  = 32'd99;
    @(negedge clk);
    check("t6_out_ready", 32'(out_ready), 0);
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    tick();
    dp_force = 1'b0;
    @(negedge clk);
    check("t6_err", 32'(err), 1);
    tick();
    @(negedge clk);
    check("t6_err_sticky", 32'(err), 1);

    // Reset with three operations outstanding
    tick();
    dp_en = 1'b0;
    for (int i = 0; i < N; i++) set_ops(i, 10 + i, 2, -3, 4, 0);
    request(0, 2);
    request(1, 1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t6_inflight3", 32'(inflight), 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_inflight", 32'(inflight), 0);
    check("t6_rst_err", 32'(err), 0);
    tick();
    dp_en = 1'b1;
    for (int i = 0; i < N; i++) set_ops(i, 10 + i, 2, -3, 4, 0);
    for (int i = 0; i < N; i++) expect_rsp(unsigned'(i), 32'(8 + 2 * i));
    for (int i = 0; i < N; i++) request(i, 1);
    @(negedge clk);
    check("t6_first_grant", 32'(req_ready), 32'b0001);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
